// File: rtl/integer_cube.sv
// Sequential unsigned cuber: result = x*x*x via one shift-add multiplier used for two passes.
// Optional INTEGER_CUBE_EARLY_EXIT_EN ends each pass once the remaining multiplier bits are zero.
module integer_cube #(
   parameter int WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     x_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [3*WIDTH-1:0]   result_o
);

   localparam int RW = 3 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SQ   = 2'd1;
   localparam logic [1:0] S_CUBE = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   op_q, op_d;
   logic [WIDTH-1:0]   shf_q, shf_d;
   logic [2*WIDTH-1:0] sq_q, sq_d;
   logic [RW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [RW-1:0]      res_q, res_d;

   logic [RW-1:0]      mcand, addend, sum;
   logic               last;

   // One datapath serves both passes; only the multiplicand source differs.
   always_comb begin
      mcand  = (state_q == S_CUBE) ? RW'(sq_q) : RW'(op_q);
      addend = shf_q[0] ? (mcand << cnt_q) : '0;
      sum    = acc_q + addend;
      last   = (cnt_q == CW'(WIDTH - 1));
`ifdef INTEGER_CUBE_EARLY_EXIT_EN
      last   = last || ((shf_q >> 1) == '0);
`endif
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      shf_d   = shf_q;
      sq_d    = sq_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               op_d    = x_i;
               shf_d   = x_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_SQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SQ, S_CUBE: begin
            if (last) begin
               acc_d = '0;
               cnt_d = '0;
               if (state_q == S_SQ) begin
                  sq_d    = sum[2*WIDTH-1:0];
                  shf_d   = op_q;
                  state_d = S_CUBE;
               end else begin
                  res_d   = sum;
                  state_d = S_DONE;
               end
            end else begin
               shf_d = shf_q >> 1;
               acc_d = sum;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         shf_q   <= '0;
         sq_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         shf_q   <= shf_d;
         sq_q    <= sq_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   assign busy_o   = (state_q == S_SQ) || (state_q == S_CUBE);
   assign done_o   = (state_q == S_DONE);
   assign result_o = res_q;

endmodule
